alu_exec_unit: RTL
==================

// Module: alu_exec_unit
// PURPOSE
//  Execute-stage datapath directly downstream of the ALU controller: consumes the
//  4-bit ALU control code plus two operands and produces a registered result.
//  AND/OR/ADD/SUB/SLT/XOR complete in one cycle; MULT runs on an iterative
//  shift-add multiplier and stalls the pipeline through ready_o until it is done.
// PARAMETERS
//  DATA_W   32   operand/result width; also the fixed MULT iteration count
// PORTS
//  clk_i       in   1        clock, rising edge
//  rst_i       in   1        asynchronous, active-low reset
//  valid_i     in   1        operation presented this cycle
//  ALUCtrl_i   in   4        op code: 0000 AND, 0001 OR, 0010 ADD, 0110 SUB, 0111 SLT, 1111 XOR, 0011 MULT
//  src1_i      in   DATA_W   operand A
//  src2_i      in   DATA_W   operand B
//  flush_i     in   1        abort the in-flight op; no result is produced
//  ready_o     out  1        unit can accept an op this cycle
//  valid_o     out  1        one-cycle pulse: result_o/zero_o updated
//  result_o    out  DATA_W   registered result, held until the next valid_o
//  zero_o      out  1        (result_o == 0), registered with result_o
// BEHAVIOUR
//  Reset (rst_i=0, async): state=IDLE, ready_o=1, valid_o=0, result_o=0, zero_o=1,
//   multiplier regs and counter cleared. Reset during MULT discards it silently.
//  Accept: edge where valid_i & ready_o & !flush_i. ready_o = (state != MUL), combinational.
//  FSM states: IDLE, MUL.
//   IDLE + accept of non-MULT op -> stay IDLE; result_o/zero_o loaded on the accept edge
//    and valid_o=1 for the following cycle (latency 1). Back-to-back accepts allowed.
//   IDLE + accept of MULT -> MUL; load mcand=src1_i, mplier=src2_i, acc=0, cnt=DATA_W;
//    valid_o=0.
//   MUL, each edge: if mplier[0] then acc+=mcand; mcand<<=1; mplier>>=1; cnt-=1.
//    On the edge where cnt goes 1->0: result_o=final acc, valid_o=1, -> IDLE.
//    valid_o therefore rises exactly DATA_W edges after the accept edge.
//   flush_i=1: state->IDLE, valid_o=0 next cycle, result_o/zero_o keep old values.
//    flush_i and valid_i in the same cycle: flush wins, op is not accepted.
//  Arithmetic: all results are DATA_W bits, modulo 2^DATA_W; no overflow flag.
//   ADD/SUB wrap. SLT is signed (two's complement): result 1 or 0, zero-extended.
//   MULT yields the low DATA_W bits of the product (identical for signed and unsigned).
//   Unlisted ALUCtrl_i code: result_o=0, zero_o=1, valid_o still pulses, latency 1.
//  valid_i while ready_o=0 is ignored; the upstream stage must hold its op.
//  valid_o is never high in two consecutive cycles following a MULT accept.
// CONFIGURATION
//  MUL_EARLY_TERM_EN defined: MUL also completes on the first edge at which the
//   shifted mplier becomes 0; MULT latency = (index of highest set bit of src2_i)+1,
//   minimum 1 edge (src2_i=0 -> result 0 one edge after accept), maximum DATA_W.
//  MUL_EARLY_TERM_EN undefined: MULT latency is always exactly DATA_W edges.
//  Results are bit-identical in both builds; only latency/ready_o timing differ.
// TESTING
//  ADD 5+7 -> valid_o on the cycle after accept, result_o=12, zero_o=0, ready_o stays 1.
//  SUB 9-9 then SLT 0xFFFFFFFF,1 back-to-back -> result 0/zero 1, then result 1/zero 0.
//  MULT 0xFFFFFFFF*3 -> ready_o low 32 cycles, valid_o 32 edges after accept, result 0xFFFFFFFD.
//  MULT 6*7, flush_i at cycle 10 with valid_i=1 -> no valid_o, ready_o=1 next cycle, op not taken.
//  rst_i low mid-MULT (cycle 15) -> outputs at reset values immediately; next ADD 1+1=2 OK.
//  MUL_EARLY_TERM_EN: MULT 6*2 -> valid_o 2 edges after accept, result 12; 6*0 -> 1 edge, 0.

Source files
------------

// File: rtl/alu_exec_unit.sv
// alu_exec_unit: execute-stage datapath fed by the ALU controller.
// Single-cycle AND/OR/ADD/SUB/SLT/XOR and an iterative shift-add MULT that
// holds ready_o low while it runs.
// Optional build macro MUL_EARLY_TERM_EN: MULT finishes as soon as the
// remaining multiplier bits are all zero instead of always taking DATA_W edges.
module alu_exec_unit #(
    parameter int unsigned DATA_W = 32
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              valid_i,
    input  logic [3:0]        ALUCtrl_i,
    input  logic [DATA_W-1:0] src1_i,
    input  logic [DATA_W-1:0] src2_i,
    input  logic              flush_i,
    output logic              ready_o,
    output logic              valid_o,
    output logic [DATA_W-1:0] result_o,
    output logic              zero_o
);

    localparam int unsigned CNT_W = $clog2(DATA_W + 1);

    localparam logic [3:0] OP_AND = 4'b0000;
    localparam logic [3:0] OP_OR  = 4'b0001;
    localparam logic [3:0] OP_ADD = 4'b0010;
    localparam logic [3:0] OP_SUB = 4'b0110;
    localparam logic [3:0] OP_SLT = 4'b0111;
    localparam logic [3:0] OP_XOR = 4'b1111;
    localparam logic [3:0] OP_MUL = 4'b0011;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_MUL  = 1'b1
    } state_t;

    state_t            state_q, state_d;
    logic [DATA_W-1:0] mcand_q, mcand_d;
    logic [DATA_W-1:0] mplier_q, mplier_d;
    logic [DATA_W-1:0] acc_q, acc_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [DATA_W-1:0] result_q, result_d;
    logic              zero_q, zero_d;
    logic              valid_q, valid_d;

    logic [DATA_W-1:0] alu_res;
    logic [DATA_W-1:0] acc_sum;
    logic              accept;
    logic              mul_done;

    assign ready_o  = (state_q != ST_MUL);
    assign accept   = valid_i & ready_o & ~flush_i;
    assign valid_o  = valid_q;
    assign result_o = result_q;
    assign zero_o   = zero_q;

    // One shift-add step: add the multiplicand when the current multiplier LSB is set.
    assign acc_sum = acc_q + (mplier_q[0] ? mcand_q : '0);

`ifdef MUL_EARLY_TERM_EN
    // Done on the last counted step or once no multiplier bits remain after this shift.
    assign mul_done = (cnt_q == CNT_W'(1)) || (mplier_q[DATA_W-1:1] == '0);
`else
    // Done on the last of the DATA_W counted steps.
    assign mul_done = (cnt_q == CNT_W'(1));
`endif

    // Single-cycle ALU result; MULT and unlisted codes produce zero here.
    always_comb begin
        alu_res = '0;
        case (ALUCtrl_i)
            OP_AND:  alu_res = src1_i & src2_i;
            OP_OR:   alu_res = src1_i | src2_i;
            OP_ADD:  alu_res = src1_i + src2_i;
            OP_SUB:  alu_res = src1_i - src2_i;
            OP_SLT:  alu_res = DATA_W'($signed(src1_i) < $signed(src2_i));
            OP_XOR:  alu_res = src1_i ^ src2_i;
            default: alu_res = '0;
        endcase
    end

    // State register.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; flush always returns to IDLE.
    always_comb begin
        state_d = state_q;
        if (flush_i) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: if (accept && (ALUCtrl_i == OP_MUL)) state_d = ST_MUL;
                ST_MUL:  if (mul_done) state_d = ST_IDLE;
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // Output and multiplier next values; a flush drops the result and keeps the old one.
    always_comb begin
        valid_d  = 1'b0;
        result_d = result_q;
        zero_d   = zero_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        if (!flush_i) begin
            case (state_q)
                ST_IDLE: begin
                    if (accept) begin
                        if (ALUCtrl_i == OP_MUL) begin
                            mcand_d  = src1_i;
                            mplier_d = src2_i;
                            acc_d    = '0;
                            cnt_d    = CNT_W'(DATA_W);
                        end else begin
                            result_d = alu_res;
                            zero_d   = (alu_res == '0);
                            valid_d  = 1'b1;
                        end
                    end
                end
                ST_MUL: begin
                    acc_d    = acc_sum;
                    mcand_d  = mcand_q << 1;
                    mplier_d = mplier_q >> 1;
                    cnt_d    = cnt_q - CNT_W'(1);
                    if (mul_done) begin
                        result_d = acc_sum;
                        zero_d   = (acc_sum == '0);
                        valid_d  = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Datapath and output registers.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            valid_q  <= 1'b0;
            result_q <= '0;
            zero_q   <= 1'b1;
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
        end else begin
            valid_q  <= valid_d;
            result_q <= result_d;
            zero_q   <= zero_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
        end
    end

endmodule
